// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and IDLE/RUN/HALT control.
// Optional fetched-word counter built only when INSTR_FETCH_COUNT_EN is defined.
module instr_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect,
    input  logic [7:0]  redirect_pc,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_rdata,
    output logic [15:0] id_instr,
    output logic [7:0]  id_pc,
    output logic        id_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [15:0] NOP_WORD  = 16'h0000;
    localparam logic [4:0]  HALT_OPC  = 5'b00001;

    // Only the top five bits are decoded; everything else passes through untouched.
    function automatic logic is_halt_op(input logic [15:0] word);
        return (word[15:11] == HALT_OPC);
    endfunction

    state_t      state_r,    state_s;
    logic [7:0]  pc_r,       pc_s;
    logic [15:0] id_instr_r, id_instr_s;
    logic [7:0]  id_pc_r,    id_pc_s;
    logic        id_valid_r, id_valid_s;
    logic        halted_r,   halted_s;

`ifdef INSTR_FETCH_COUNT_EN
    logic [15:0] fetch_count_r, fetch_count_s;
`endif

    // Next-state and next-register computation for the fetch controller.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        id_instr_s = id_instr_r;
        id_pc_s    = id_pc_r;
        id_valid_s = id_valid_r;
`ifdef INSTR_FETCH_COUNT_EN
        fetch_count_s = fetch_count_r;
`endif
        case (state_r)
            ST_IDLE: begin
                pc_s       = 8'd0;
                id_instr_s = NOP_WORD;
                id_valid_s = 1'b0;
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN, ST_HALT: begin
                if (redirect) begin
                    state_s    = ST_RUN;
                    pc_s       = redirect_pc;
                    id_instr_s = NOP_WORD;
                    id_valid_s = 1'b0;
                end else if (stall) begin
                    state_s = state_r;
                end else if (state_r == ST_RUN) begin
                    id_instr_s = imem_rdata;
                    id_pc_s    = pc_r;
                    id_valid_s = 1'b1;
`ifdef INSTR_FETCH_COUNT_EN
                    fetch_count_s = fetch_count_r + 16'd1;
`endif
                    // A HALT word freezes the PC on the very edge it is captured.
                    if (is_halt_op(imem_rdata)) begin
                        state_s = ST_HALT;
                    end else begin
                        pc_s = pc_r + 8'd1;
                    end
                end else begin
                    id_instr_s = NOP_WORD;
                    id_valid_s = 1'b0;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                pc_s       = 8'd0;
                id_instr_s = NOP_WORD;
                id_valid_s = 1'b0;
            end
        endcase
        halted_s = (state_s == ST_HALT);
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            pc_r       <= 8'd0;
            id_instr_r <= NOP_WORD;
            id_pc_r    <= 8'd0;
            id_valid_r <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            id_instr_r <= id_instr_s;
            id_pc_r    <= id_pc_s;
            id_valid_r <= id_valid_s;
            halted_r   <= halted_s;
        end
    end

`ifdef INSTR_FETCH_COUNT_EN
    // Fetched-word counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_r <= 16'd0;
        end else begin
            fetch_count_r <= fetch_count_s;
        end
    end

    assign fetch_count = fetch_count_r;
`else
    assign fetch_count = 16'd0;
`endif

    assign imem_addr = pc_r;
    assign id_instr  = id_instr_r;
    assign id_pc     = id_pc_r;
    assign id_valid  = id_valid_r;
    assign halted    = halted_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a combinational instruction memory model.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] id_instr;
    logic [7:0]  id_pc;
    logic        id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [0:255];
    int          n_checks;
    int          n_fails;
    logic [15:0] exp_count_after_halt;

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_valid    (id_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    assign imem_rdata = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
`ifdef INSTR_FETCH_COUNT_EN
        exp_count_after_halt = 16'd4;
`else
        exp_count_after_halt = 16'd0;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]    = 16'h4f10;
        mem[1]    = 16'h81b6;
        mem[2]    = 16'h1970;
        mem[3]    = 16'h0800;
        mem[8'h10] = 16'h2222;
        mem[8'h11] = 16'h3333;
        mem[8'h4f] = 16'h1234;
        mem[8'h52] = 16'h0801;
        mem[8'h53] = 16'h5555;
        mem[8'h55] = 16'h6666;

        reset = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        step();
        step();
        reset = 1'b0;

        // Reset / IDLE state
        check("rst_addr",  {8'h00, imem_addr}, 16'h0000);
        check("rst_instr", id_instr,           16'h0000);
        check("rst_valid", {15'd0, id_valid},  16'h0000);
        check("rst_halt",  {15'd0, halted},    16'h0000);
        check("rst_count", fetch_count,        16'h0000);

        step();
        check("idle_hold_addr", {8'h00, imem_addr}, 16'h0000);

        start = 1'b1;
        step();
        start = 1'b0;
        check("run_addr0",  {8'h00, imem_addr}, 16'h0000);
        check("run_valid0", {15'd0, id_valid},  16'h0000);

        step();
        check("f0_instr", id_instr,          16'h4f10);
        check("f0_pc",    {8'h00, id_pc},    16'h0000);
        check("f0_valid", {15'd0, id_valid}, 16'h0001);

        step();
        check("f1_instr", id_instr,          16'h81b6);
        check("f1_pc",    {8'h00, id_pc},    16'h0001);

        // Two stall cycles hold IF/ID and PC
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("stall_instr", id_instr,           16'h81b6);
            check("stall_pc",    {8'h00, id_pc},     16'h0001);
            check("stall_addr",  {8'h00, imem_addr}, 16'h0002);
            check("stall_valid", {15'd0, id_valid},  16'h0001);
        end
        stall = 1'b0;

        step();
        check("f2_instr", id_instr,       16'h1970);
        check("f2_pc",    {8'h00, id_pc}, 16'h0002);

        step();
        check("halt_instr", id_instr,           16'h0800);
        check("halt_pc",    {8'h00, id_pc},     16'h0003);
        check("halt_flag",  {15'd0, halted},    16'h0001);
        check("halt_addr",  {8'h00, imem_addr}, 16'h0003);

        step();
        check("halt_bub_instr", id_instr,           16'h0000);
        check("halt_bub_valid", {15'd0, id_valid},  16'h0000);
        check("halt_bub_addr",  {8'h00, imem_addr}, 16'h0003);
        check("halt_bub_flag",  {15'd0, halted},    16'h0001);
        check("halt_count",     fetch_count,        exp_count_after_halt);

        // Redirect out of HALT
        redirect = 1'b1; redirect_pc = 8'h10;
        step();
        redirect = 1'b0;
        check("rdh_addr",  {8'h00, imem_addr}, 16'h0010);
        check("rdh_flag",  {15'd0, halted},    16'h0000);
        check("rdh_valid", {15'd0, id_valid},  16'h0000);

        step();
        check("rdh_f_instr", id_instr,           16'h2222);
        check("rdh_f_pc",    {8'h00, id_pc},     16'h0010);
        check("rdh_f_addr",  {8'h00, imem_addr}, 16'h0011);

        // Redirect wins over simultaneous stall in RUN
        redirect = 1'b1; stall = 1'b1; redirect_pc = 8'h4f;
        step();
        redirect = 1'b0; stall = 1'b0;
        check("rds_addr",  {8'h00, imem_addr}, 16'h004f);
        check("rds_valid", {15'd0, id_valid},  16'h0000);
        check("rds_instr", id_instr,           16'h0000);

        step();
        check("rds_f_instr", id_instr,          16'h1234);
        check("rds_f_pc",    {8'h00, id_pc},    16'h004f);
        check("rds_f_valid", {15'd0, id_valid}, 16'h0001);

        // HALT word at 0x52, then redirect to 0x55
        redirect = 1'b1; redirect_pc = 8'h52;
        step();
        redirect = 1'b0;
        step();
        check("h52_instr", id_instr,           16'h0801);
        check("h52_pc",    {8'h00, id_pc},     16'h0052);
        check("h52_flag",  {15'd0, halted},    16'h0001);
        check("h52_addr",  {8'h00, imem_addr}, 16'h0052);

        stall = 1'b1; start = 1'b1;
        step();
        stall = 1'b0; start = 1'b0;
        check("hstall_instr", id_instr,           16'h0801);
        check("hstall_valid", {15'd0, id_valid},  16'h0001);
        check("hstall_flag",  {15'd0, halted},    16'h0001);
        check("hstall_addr",  {8'h00, imem_addr}, 16'h0052);

        redirect = 1'b1; redirect_pc = 8'h55;
        step();
        redirect = 1'b0;
        check("h55_flag", {15'd0, halted},    16'h0000);
        check("h55_addr", {8'h00, imem_addr}, 16'h0055);

        step();
        check("h55_instr", id_instr,        16'h6666);
        check("h55_pc",    {8'h00, id_pc},  16'h0055);
        check("h55_flag2", {15'd0, halted}, 16'h0000);

        // PC wrap 0xFF -> 0x00
        redirect = 1'b1; redirect_pc = 8'hfe;
        step();
        redirect = 1'b0;
        step();
        check("wrap_pc_fe",   {8'h00, id_pc},     16'h00fe);
        step();
        check("wrap_pc_ff",   {8'h00, id_pc},     16'h00ff);
        check("wrap_addr_00", {8'h00, imem_addr}, 16'h0000);
        step();
        check("wrap_pc_00",   {8'h00, id_pc},     16'h0000);
        check("wrap_instr",   id_instr,           16'h4f10);
        check("wrap_nohalt",  {15'd0, halted},    16'h0000);

        // Reset mid-RUN at pc 0x30 overrides start/redirect
        redirect = 1'b1; redirect_pc = 8'h30;
        step();
        redirect = 1'b0;
        check("pre_rst_addr", {8'h00, imem_addr}, 16'h0030);
        reset = 1'b1; start = 1'b1; redirect = 1'b1; redirect_pc = 8'h77;
        step();
        reset = 1'b0; start = 1'b0; redirect = 1'b0;
        check("mrst_addr",  {8'h00, imem_addr}, 16'h0000);
        check("mrst_valid", {15'd0, id_valid},  16'h0000);
        check("mrst_instr", id_instr,           16'h0000);
        check("mrst_pc",    {8'h00, id_pc},     16'h0000);
        check("mrst_count", fetch_count,        16'h0000);

        // Redirect ignored in IDLE
        redirect = 1'b1; redirect_pc = 8'h77;
        step();
        redirect = 1'b0;
        check("idle_rd_addr",  {8'h00, imem_addr}, 16'h0000);
        step();
        check("idle_rd_valid", {15'd0, id_valid},  16'h0000);
        check("idle_rd_addr2", {8'h00, imem_addr}, 16'h0000);

        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("restart_instr", id_instr,          16'h4f10);
        check("restart_pc",    {8'h00, id_pc},    16'h0000);
        check("restart_valid", {15'd0, id_valid}, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
